// File: rtl/mmu_pkg.sv
// mmu_pkg: register map, region boundaries and region enum shared by the MMU decoder.
// MMU_WRITE_PROTECT_EN extends the register block with wp_mask and status.
package mmu_pkg;
    localparam logic [15:0] IO_BANK_L_ADDR = 16'h0000;
    localparam logic [15:0] IO_BANK_H_ADDR = 16'h0001;
    localparam logic [15:0] ROM_CTRL_ADDR  = 16'h0002;
    localparam logic [15:0] WIN_PAGE_ADDR  = 16'h0003;
    localparam logic [15:0] WIN_PAGE_LAST  = 16'h000A;
`ifdef MMU_WRITE_PROTECT_EN
    localparam logic [15:0] WP_MASK_ADDR   = 16'h000B;
    localparam logic [15:0] STATUS_ADDR    = 16'h000C;
    localparam logic [15:0] DEC_LAST       = 16'h000C;
`else
    localparam logic [15:0] DEC_LAST       = 16'h000A;
`endif
    localparam logic [15:0] ROM_WIN_BASE   = 16'hE000;
    localparam logic [15:0] IO_BASE        = 16'hFE00;
    localparam logic [15:0] ROM_BASE       = 16'hFF00;
    localparam int          WIN_SHIFT      = 13;

    typedef enum logic [2:0] {REG_DEC, REG_ROM, REG_IO, REG_RAM, REG_NONE} region_e;

    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mmu_region_decode.sv
// mmu_region_decode: priority address decode of the CPU address into a region and IO bank index.
module mmu_region_decode import mmu_pkg::*; #(
    parameter int NUM_IO_BANKS = 16
) (
    input  logic [15:0]                       addr_i,
    input  logic                              rom_in_i,
    input  logic [15:0]                       bank_i,
    output region_e                           region_o,
    output logic [bank_w(NUM_IO_BANKS)-1:0]   bank_idx_o
);
    logic bank_ok;

    // An out-of-range bank selects nothing rather than falling through to RAM.
    assign bank_ok    = bank_i < 16'(NUM_IO_BANKS);
    assign bank_idx_o = bank_i[bank_w(NUM_IO_BANKS)-1:0];
    assign region_o   = (addr_i <= DEC_LAST)     ? REG_DEC :
                        (addr_i >= ROM_BASE)     ? REG_ROM :
                        (addr_i >= IO_BASE)      ? (bank_ok ? REG_IO : REG_NONE) :
                        (addr_i >= ROM_WIN_BASE) ? (rom_in_i ? REG_ROM : REG_RAM) :
                                                   REG_RAM;
endmodule

// File: rtl/mmu_addr_decoder.sv
// mmu_addr_decoder: 8-window MMU with control registers and registered chip selects.
// Optional write protection via MMU_WRITE_PROTECT_EN.
module mmu_addr_decoder import mmu_pkg::*; #(
    parameter int NUM_IO_BANKS = 16,
    parameter int EXT_ADDR_W   = 20
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [15:0]             addr_i,
    input  logic                    we_i,
    input  logic [7:0]              data_i,
    output logic [7:0]              data_o,
    output logic [EXT_ADDR_W-1:0]   ext_addr_o,
    output logic [EXT_ADDR_W-1:0]   ext_addr_w_o,
    output logic                    ram_cs_o,
    output logic                    ram_we_o,
    output logic                    rom_cs_o,
    output logic                    dec_cs_o,
    output logic [NUM_IO_BANKS-1:0] io_cs_o
);
    localparam int PW = EXT_ADDR_W - WIN_SHIFT;
    localparam logic [NUM_IO_BANKS-1:0] IO_ONE = 1;

    logic [7:0]                      io_bank_l, io_bank_h, rdata, wp_rdata;
    logic                            rom_ctrl, wr_reg, viol, ram_sel;
    logic [PW-1:0]                   win_page [8];
    logic [15:0]                     page_wdata;
    logic [2:0]                      win, pidx;
    region_e                         region;
    logic [bank_w(NUM_IO_BANKS)-1:0] bank_idx;

    mmu_region_decode #(.NUM_IO_BANKS(NUM_IO_BANKS)) u_region (
        .addr_i     (addr_i),
        .rom_in_i   (~rom_ctrl),
        .bank_i     ({io_bank_h, io_bank_l}),
        .region_o   (region),
        .bank_idx_o (bank_idx)
    );

    assign win        = addr_i[15:13];
    assign pidx       = addr_i[2:0] - 3'd3;
    assign ext_addr_o = {win_page[win], addr_i[12:0]};
    assign wr_reg     = we_i && region == REG_DEC;
    // Wide EXT_ADDR_W borrows the page bits above data_i from io_bank_h.
    assign page_wdata = {io_bank_h, data_i};
    assign ram_sel    = region == REG_RAM && !viol;
    assign rdata      = (addr_i == IO_BANK_L_ADDR) ? io_bank_l :
                        (addr_i == IO_BANK_H_ADDR) ? io_bank_h :
                        (addr_i == ROM_CTRL_ADDR)  ? {7'd0, rom_ctrl} :
                        (addr_i >= WIN_PAGE_ADDR && addr_i <= WIN_PAGE_LAST) ? 8'(win_page[pidx]) :
                        wp_rdata;

`ifdef MMU_WRITE_PROTECT_EN
    logic [7:0] wp_mask;
    logic       status;

    assign viol     = we_i && region == REG_RAM && wp_mask[win];
    assign wp_rdata = (addr_i == WP_MASK_ADDR) ? wp_mask :
                      (addr_i == STATUS_ADDR)  ? {7'd0, status} : 8'd0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp_mask <= '0;
            status  <= 1'b0;
        end else begin
            if (wr_reg && addr_i == WP_MASK_ADDR) wp_mask <= data_i;
            status <= viol ? 1'b1 : (wr_reg && addr_i == STATUS_ADDR && data_i[0]) ? 1'b0 : status;
        end
    end
`else
    assign viol     = 1'b0;
    assign wp_rdata = 8'd0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            io_bank_l    <= '0;
            io_bank_h    <= '0;
            rom_ctrl     <= 1'b0;
            for (int w = 0; w < 8; w++) win_page[w] <= PW'(w);
            data_o       <= '0;
            ext_addr_w_o <= '0;
            ram_cs_o     <= 1'b0;
            ram_we_o     <= 1'b0;
            rom_cs_o     <= 1'b0;
            dec_cs_o     <= 1'b0;
            io_cs_o      <= '0;
        end else begin
            if (wr_reg && addr_i == IO_BANK_L_ADDR) io_bank_l <= data_i;
            if (wr_reg && addr_i == IO_BANK_H_ADDR) io_bank_h <= data_i;
            if (wr_reg && addr_i == ROM_CTRL_ADDR) rom_ctrl <= data_i[0];
            for (int w = 0; w < 8; w++)
                if (wr_reg && addr_i == WIN_PAGE_ADDR + 16'(w)) win_page[w] <= page_wdata[PW-1:0];
            data_o       <= rdata;
            ext_addr_w_o <= ext_addr_o;
            ram_cs_o     <= ram_sel;
            ram_we_o     <= ram_sel && we_i;
            rom_cs_o     <= region == REG_ROM && !we_i;
            dec_cs_o     <= region == REG_DEC;
            io_cs_o      <= (region == REG_IO) ? IO_ONE << bank_idx : '0;
        end
    end
endmodule
